// File: rtl/lcg_stim_sequencer.sv
// Stallable LCG stimulus sequencer: expands a seed into IN_W-bit vectors and hands them out over valid/ready.
// Optional output signature (MISR over dut_out) is enabled with `define SIGNATURE_EN.
module lcg_stim_sequencer #(
    parameter int IN_W  = 263,
    parameter int OUT_W = 330,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_vectors,
    output logic [IN_W-1:0]  vec,
    output logic             vec_valid,
    input  logic             vec_ready,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [31:0]      signature
);

    localparam int NWORDS = (IN_W + 31) / 32;
    localparam int LAST_W = IN_W - 32 * (NWORDS - 1);
    localparam int IDX_W  = $clog2(NWORDS + 1);
    localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC = 32'h0000_3039;

`ifdef SIGNATURE_EN
    localparam int OWORDS = (OUT_W + 31) / 32;

    // XOR of every 32-bit slice of d, top slice zero-padded.
    function automatic logic [31:0] fold32(input logic [OUT_W-1:0] d);
        logic [32*OWORDS-1:0] pad;
        logic [31:0]          acc;
        pad = '0;
        pad[OUT_W-1:0] = d;
        acc = 32'd0;
        for (int k = 0; k < OWORDS; k++) begin
            acc = acc ^ pad[32*k +: 32];
        end
        return acc;
    endfunction
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           state_r, state_n;
    logic [31:0]      lcg_r;
    logic [IN_W-1:0]  shadow_r;
    logic [IDX_W-1:0] word_idx_r;
    logic [IN_W-1:0]  vec_r;
    logic             vec_valid_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] vec_count_r;
    logic [CNT_W-1:0] num_r;
    logic [31:0]      sig_r;

    logic             accept_s;
    logic             fill_s;
    logic             hs_s;
    logic             last_word_s;
    logic [31:0]      lcg_n_s;
    logic [IN_W-1:0]  shadow_n_s;
    logic [31:0]      sig_n_s;

    assign last_word_s = (word_idx_r == IDX_W'(NWORDS - 1));

    // Next-state decode; abort overrides both start and handshake.
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        fill_s   = 1'b0;
        hs_s     = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        accept_s = 1'b1;
                        state_n  = (num_vectors == '0) ? ST_DONE : ST_FILL;
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_FILL: begin
                    fill_s  = 1'b1;
                    state_n = last_word_s ? ST_PRESENT : ST_FILL;
                end
                ST_PRESENT: begin
                    if (vec_ready) begin
                        hs_s    = 1'b1;
                        state_n = ((vec_count_r + CNT_W'(1)) == num_r) ? ST_DONE : ST_FILL;
                    end else begin
                        state_n = ST_PRESENT;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // LCG step and shadow word insertion; the final word keeps only the low LAST_W bits.
    always_comb begin
        lcg_n_s    = lcg_r * LCG_MUL + LCG_INC;
        shadow_n_s = shadow_r;
        for (int k = 0; k < NWORDS - 1; k++) begin
            shadow_n_s[32*k +: 32] = (word_idx_r == IDX_W'(k)) ? lcg_n_s : shadow_r[32*k +: 32];
        end
        shadow_n_s[IN_W-1 -: LAST_W] = last_word_s ? lcg_n_s[LAST_W-1:0] : shadow_r[IN_W-1 -: LAST_W];
    end

`ifdef SIGNATURE_EN
    // MISR update applied on each handshake.
    always_comb begin
        sig_n_s = {sig_r[30:0], sig_r[31]} ^ fold32(dut_out);
    end
`else
    logic unused_dut_out_s;
    assign unused_dut_out_s = ^dut_out;

    // Signature disabled: next value is always zero.
    always_comb begin
        sig_n_s = 32'd0;
    end
`endif

    // State, datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            lcg_r       <= 32'd0;
            shadow_r    <= '0;
            word_idx_r  <= '0;
            vec_r       <= '0;
            vec_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            vec_count_r <= '0;
            num_r       <= '0;
            sig_r       <= 32'd0;
        end else begin
            state_r     <= state_n;
            vec_valid_r <= (state_n == ST_PRESENT);
            busy_r      <= (state_n == ST_FILL) || (state_n == ST_PRESENT);
            done_r      <= (state_n == ST_DONE);
            if (accept_s) begin
                lcg_r       <= seed;
                num_r       <= num_vectors;
                word_idx_r  <= '0;
                vec_count_r <= '0;
                sig_r       <= 32'd0;
            end else begin
                if (fill_s) begin
                    lcg_r      <= lcg_n_s;
                    shadow_r   <= shadow_n_s;
                    word_idx_r <= last_word_s ? '0 : word_idx_r + IDX_W'(1);
                    if (last_word_s) begin
                        vec_r <= shadow_n_s;
                    end
                end
                if (hs_s) begin
                    vec_count_r <= vec_count_r + CNT_W'(1);
                    sig_r       <= sig_n_s;
                end
            end
        end
    end

    assign vec       = vec_r;
    assign vec_valid = vec_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign vec_count = vec_count_r;
    assign signature = sig_r;

endmodule

// File: tb/tb_lcg_stim_sequencer.sv
// Self-checking bench for lcg_stim_sequencer: directed scenarios plus randomized runs against a vector/signature model.
module tb_lcg_stim_sequencer;

    localparam int IN_W  = 263;
    localparam int OUT_W = 330;
    localparam int CNT_W = 32;
    localparam int NW    = (IN_W + 31) / 32;
    localparam int ONW   = (OUT_W + 31) / 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [31:0]      seed;
    logic [CNT_W-1:0] num_vectors;
    logic [IN_W-1:0]  vec;
    logic             vec_valid;
    logic             vec_ready;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_count;
    logic [31:0]      signature;

    int tests;
    int fails;
    int cyc;

    lcg_stim_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .num_vectors(num_vectors), .vec(vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .dut_out(dut_out), .busy(busy), .done(done), .vec_count(vec_count), .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one vector = NW successive LCG states laid end to end, truncated to IN_W.
    function automatic logic [IN_W-1:0] model_vec(inout logic [31:0] st);
        logic [32*NW-1:0] b;
        b = '0;
        for (int k = 0; k < NW; k++) begin
            st = st * 32'h41C64E6D + 32'h00003039;
            b[32*k +: 32] = st;
        end
        return b[IN_W-1:0];
    endfunction

    function automatic logic [31:0] model_fold(input logic [OUT_W-1:0] d);
        logic [32*ONW-1:0] p;
        logic [31:0] r;
        p = '0;
        p[OUT_W-1:0] = d;
        r = 32'd0;
        for (int k = 0; k < ONW; k++) r = r ^ p[32*k +: 32];
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] rand_out();
        logic [32*ONW-1:0] t;
        for (int k = 0; k < ONW; k++) t[32*k +: 32] = $urandom;
        return t[OUT_W-1:0];
    endfunction

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (vec_valid) break;
            tick();
        end
        check(tag, vec_valid, 1);
    endtask

    // Full run: start, drain all vectors with random backpressure, check data, latency and completion.
    task automatic run(input logic [31:0] s, input int n, input int rdy_pct, input int stall_n,
                       input bit dut_one, output logic [IN_W-1:0] first_vec, output int span);
        logic [IN_W-1:0] expq[$];
        logic [31:0] st;
        logic [31:0] exp_sig;
        logic [IN_W-1:0] e;
        int hs, stalls, last_edge, acc_edge, budget;
        bit prev_valid, hs_now;
        st = s;
        for (int i = 0; i < n; i++) expq.push_back(model_vec(st));
        exp_sig = 32'd0;
        first_vec = '0;
        abort = 1'b0;
        seed = s;
        num_vectors = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        acc_edge = cyc;
        last_edge = cyc;
        hs = 0; stalls = 0; budget = 0; prev_valid = 1'b0;
        while (!done && budget < 4000) begin
            e = (hs < expq.size()) ? expq[hs] : '0;
            if (vec_valid && !prev_valid) begin
                check("latency", cyc - last_edge, NW);
                check("vec", vec, e);
                if (hs == 0) first_vec = vec;
            end else if (vec_valid) begin
                check("vec_stable", vec, e);
            end
            prev_valid = vec_valid;
            if (vec_valid && stalls < stall_n) begin
                vec_ready = 1'b0;
                stalls++;
            end else begin
                vec_ready = ($urandom_range(99) < rdy_pct);
            end
            dut_out = dut_one ? OUT_W'(1) : rand_out();
            hs_now = vec_valid && vec_ready;
            if (hs_now) begin
                exp_sig = {exp_sig[30:0], exp_sig[31]} ^ model_fold(dut_out);
                hs++;
            end
            tick();
            if (hs_now) begin
                last_edge = cyc;
                check("valid_drop", vec_valid, 0);
            end
            budget++;
        end
        vec_ready = 1'b0;
        span = cyc - acc_edge;
        check("timeout", budget < 4000, 1);
        check("done", done, 1);
        check("count", vec_count, n);
        check("handshakes", hs, n);
        check("busy_end", busy, 0);
        check("valid_end", vec_valid, 0);
`ifdef SIGNATURE_EN
        check("signature", signature, exp_sig);
`else
        check("signature", signature, 0);
`endif
    endtask

    initial begin
        logic [IN_W-1:0] fv, e0, e1;
        logic [31:0] st, s;
        int sp;
        tests = 0; fails = 0; cyc = 0;
        clk = 1'b0; rst = 1'b1; start = 1'b0; abort = 1'b0; seed = 32'd0;
        num_vectors = '0; vec_ready = 1'b0; dut_out = '0;

        // T1 reset
        tick(); tick();
        check("rst_vec", vec, 0);
        check("rst_valid", vec_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", vec_count, 0);
        check("rst_sig", signature, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // T2 single vector from seed 1
        run(32'd1, 1, 100, 0, 1'b0, fv, sp);
        check("t2_lo", fv[31:0], 32'h41C67EA6);
        check("t2_done_cycle", sp, NW + 1);

        // T3 backpressure on the first vector
        run(32'd0, 3, 100, 5, 1'b0, fv, sp);
        check("t3_lo", fv[31:0], 32'h00003039);

        // done held across idle cycles
        tick(); tick();
        check("done_held", done, 1);

        // T4 zero count
        num_vectors = '0; seed = $urandom; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_done", done, 1);
        check("t4_valid", vec_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_valid_never", vec_valid, 0);
        end

        // T5a: start in FILL ignored, abort wins over a handshake in PRESENT
        s = $urandom; st = s;
        e0 = model_vec(st); e1 = model_vec(st);
        seed = s; num_vectors = 3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("t5a_wait0");
        check("t5a_v0", vec, e0);
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        tick(); tick();
        seed = ~s; num_vectors = 1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5a_busy", busy, 1);
        wait_valid("t5a_wait1");
        check("t5a_v1", vec, e1);
        check("t5a_cnt", vec_count, 1);
        abort = 1'b1; vec_ready = 1'b1;
        tick();
        abort = 1'b0; vec_ready = 1'b0;
        check("t5a_valid", vec_valid, 0);
        check("t5a_busy_off", busy, 0);
        check("t5a_cnt_kept", vec_count, 1);
        check("t5a_vec_kept", vec, e1);

        // T5b: abort in FILL of vector 2
        seed = s; num_vectors = 3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("t5b_wait0");
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5b_busy", busy, 0);
        check("t5b_done", done, 0);
        check("t5b_valid", vec_valid, 0);
        check("t5b_cnt", vec_count, 1);
        check("t5b_vec", vec, e0);
        tick(); tick();
        check("t5b_idle", busy, 0);

        // T6 signature with dut_out = 1
        run($urandom, 2, 100, 0, 1'b1, fv, sp);
`ifdef SIGNATURE_EN
        check("t6_sig", signature, 32'h00000003);
`else
        check("t6_sig", signature, 32'h00000000);
`endif

        // rst mid-run discards a pending handshake
        seed = $urandom; num_vectors = 2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("rst_wait");
        vec_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; vec_ready = 1'b0;
        check("mrst_count", vec_count, 0);
        check("mrst_valid", vec_valid, 0);
        check("mrst_vec", vec, 0);
        check("mrst_busy", busy, 0);
        check("mrst_sig", signature, 0);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            run($urandom, $urandom_range(4, 1), $urandom_range(100, 30), $urandom_range(3, 0), 1'b0, fv, sp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
